// File: rtl/mips_isa_pkg.sv
// MIPS opcode, field and encoding definitions shared by the
// instruction-mix profiler and its counters.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

  typedef enum logic [1:0] {
    IT_NONE,
    IT_R,
    IT_I,
    IT_J
  } itype_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  // Branches and stores are I type but write no register.
  function automatic logic no_dest(input logic [5:0] op);
    return (op == OP_REGIMM) || (op == OP_BEQ) ||
           (op == OP_BNE)    || (op == OP_BLEZ) ||
           (op == OP_BGTZ)   || (op == OP_SB) ||
           (op == OP_SH)     || (op == OP_SW);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, used for every
// statistic the profiler keeps.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/instr_mix_profiler.sv
// Walks an instruction memory once per start, classifying words by
// type and counting writes to a window of destination registers.
module instr_mix_profiler
  import mips_isa_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int AW           = 8,
  parameter int CNT_W        = 4,
  parameter int NREG         = 4,
  parameter int REG_BASE     = 3,
  parameter int STOP_ON_ZERO = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    sel,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_data,
  output logic          busy,
  output logic          done,
  output logic [7:0]    led
);

  state_e state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d, addr_q, addr_d;
  logic iss_q, iss_d, vld_q, vld_d;
  logic stop_q, stop_d;
  logic [AW:0] tot_q, tot_d;
  logic [7:0] led_q, led_d;

  logic clr, take, zero_hit, has_dest;
  logic [5:0] op;
  logic [4:0] dest;
  itype_e ity;
  logic [NREG-1:0] reg_inc;
  logic [CNT_W-1:0] r_cnt, i_cnt, j_cnt;
  logic [CNT_W-1:0] reg_cnt [NREG];
  logic [1:0] reg_lo [4];

  assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done = (state_q == S_DONE);
  assign clr  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign imem_addr = addr_q;
  assign led = led_q;

  assign zero_hit = (STOP_ON_ZERO != 0) && vld_q && busy &&
                    (imem_data == 32'd0);
  assign take = vld_q && busy && !zero_hit;

  always_comb begin
    op = imem_data[OP_HI:OP_LO];
    ity = IT_I;
    dest = imem_data[RT_HI:RT_LO];
    has_dest = 1'b1;
    unique case (1'b1)
      (op == OP_RTYPE): begin
        ity = IT_R;
        dest = imem_data[RD_HI:RD_LO];
      end
      ((op == OP_J) || (op == OP_JAL)): begin
        ity = IT_J;
        has_dest = 1'b0;
      end
      no_dest(op): has_dest = 1'b0;
      default: ;
    endcase
  end

  always_comb begin
    reg_inc = '0;
    for (int k = 0; k < NREG; k++) begin
      reg_inc[k] = take && has_dest &&
                   (32'(dest) == 32'(REG_BASE + k));
    end
  end

  sat_counter #(.W(CNT_W)) u_r_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .inc(take && (ity == IT_R)), .q(r_cnt)
  );
  sat_counter #(.W(CNT_W)) u_i_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .inc(take && (ity == IT_I)), .q(i_cnt)
  );
  sat_counter #(.W(CNT_W)) u_j_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .inc(take && (ity == IT_J)), .q(j_cnt)
  );

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .inc(reg_inc[g]), .q(reg_cnt[g])
    );
  end

  for (genvar g = 0; g < 4; g++) begin : g_lo
    if (g < NREG) begin : g_on
      assign reg_lo[g] = reg_cnt[g][1:0];
    end else begin : g_off
      assign reg_lo[g] = 2'b00;
    end
  end

  // vld trails iss by one cycle to cover the memory read latency.
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    addr_d = addr_q;
    iss_d = 1'b0;
    vld_d = iss_q;
    stop_d = stop_q;
    tot_d = tot_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          ptr_d = '0;
          stop_d = 1'b0;
          tot_d = '0;
        end
      end
      S_RUN: begin
        addr_d = ptr_q;
        iss_d = 1'b1;
        if (ptr_q == AW'(DEPTH - 1)) begin
          state_d = S_DRAIN;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (vld_q && !iss_q) begin
          state_d = S_DONE;
        end
      end
      default: ;
    endcase
    if (take) begin
      tot_d = tot_q + 1'b1;
    end
    if (zero_hit) begin
      state_d = S_DONE;
      ptr_d = ptr_q;
      addr_d = addr_q;
      iss_d = 1'b0;
      vld_d = 1'b0;
      stop_d = 1'b1;
    end
  end

  always_comb begin
    led_d = 8'd0;
    unique case (sel)
      2'b00: led_d = {j_cnt[1:0], i_cnt[2:0], r_cnt[2:0]};
      2'b01: led_d = {reg_lo[3], reg_lo[2], reg_lo[1], reg_lo[0]};
      2'b10: led_d = tot_q[7:0];
      2'b11: led_d = {busy, done, stop_q, ptr_q[4:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q <= '0;
      addr_q <= '0;
      iss_q <= 1'b0;
      vld_q <= 1'b0;
      stop_q <= 1'b0;
      tot_q <= '0;
      led_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      addr_q <= addr_d;
      iss_q <= iss_d;
      vld_q <= vld_d;
      stop_q <= stop_d;
      tot_q <= tot_d;
      led_q <= led_d;
    end
  end

endmodule

// File: tb/tb_instr_mix_profiler.sv
// Directed bench: three profiler configurations, a table of LED
// expectations and hand-written timing/reset/restart sequences.
module tb_instr_mix_profiler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start [3];
  logic [1:0]  sel   [3];
  logic [7:0]  addr  [3];
  logic [31:0] data  [3];
  logic        busy  [3];
  logic        done  [3];
  logic [7:0]  led   [3];

  logic [31:0] mem_a [4];
  logic [31:0] mem_b [20];
  logic [31:0] mem_c [8];

  int checks = 0;
  int errors = 0;

  initial begin
    for (int u = 0; u < 3; u++) begin
      start[u] = 1'b0;
      sel[u] = 2'b00;
      data[u] = 32'd0;
    end
  end

  instr_mix_profiler #(.DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .sel(sel[0]),
    .imem_addr(addr[0]), .imem_data(data[0]),
    .busy(busy[0]), .done(done[0]), .led(led[0])
  );

  instr_mix_profiler #(.DEPTH(20)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .sel(sel[1]),
    .imem_addr(addr[1]), .imem_data(data[1]),
    .busy(busy[1]), .done(done[1]), .led(led[1])
  );

  instr_mix_profiler #(.DEPTH(8), .STOP_ON_ZERO(1)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .sel(sel[2]),
    .imem_addr(addr[2]), .imem_data(data[2]),
    .busy(busy[2]), .done(done[2]), .led(led[2])
  );

  always @(posedge clk) begin
    data[0] <= (addr[0] < 8'd4)  ? mem_a[addr[0][1:0]] : 32'd0;
    data[1] <= (addr[1] < 8'd20) ? mem_b[addr[1]]       : 32'd0;
    data[2] <= (addr[2] < 8'd8)  ? mem_c[addr[2][2:0]]  : 32'd0;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic show(input int u, input logic [1:0] s,
                      input logic [7:0] exp, input string nm);
    sel[u] = s;
    repeat (2) @(posedge clk);
    #1;
    chk(nm, 32'(led[u]), 32'(exp));
  endtask

  task automatic wait_done(input int u, input string nm);
    int n = 0;
    while (!done[u] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, 32'(done[u]), 32'd1);
  endtask

  task automatic pulse(input int u);
    @(negedge clk);
    start[u] = 1'b1;
    @(posedge clk);
    #1;
    start[u] = 1'b0;
  endtask

  typedef struct {
    int         u;
    logic [1:0] s;
    logic [7:0] exp;
    string      nm;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{0, 2'b00, 8'h51, "a_mix"};
    tbl[1]  = '{0, 2'b01, 8'h08, "a_regs"};
    tbl[2]  = '{0, 2'b10, 8'h04, "a_total"};
    tbl[3]  = '{0, 2'b11, 8'h43, "a_status"};
    tbl[4]  = '{1, 2'b00, 8'h38, "b_mix_sat"};
    tbl[5]  = '{1, 2'b01, 8'h03, "b_regs_sat"};
    tbl[6]  = '{1, 2'b10, 8'h14, "b_total"};
    tbl[7]  = '{1, 2'b11, 8'h53, "b_status"};
    tbl[8]  = '{2, 2'b00, 8'h09, "c_mix"};
    tbl[9]  = '{2, 2'b01, 8'h08, "c_regs"};
    tbl[10] = '{2, 2'b10, 8'h02, "c_total"};
    tbl[11] = '{2, 2'b11, 8'h64, "c_status"};

    mem_a[0] = 32'h20043456;
    mem_a[1] = 32'h00852020;
    mem_a[2] = 32'h08000010;
    mem_a[3] = 32'hAC050000;
    for (int k = 0; k < 20; k++) mem_b[k] = 32'h20030001;
    mem_c[0] = 32'h20043456;
    mem_c[1] = 32'h00852020;
    mem_c[2] = 32'h00000000;
    for (int k = 3; k < 8; k++) mem_c[k] = 32'h08000010;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_led_a", 32'(led[0]), 32'd0);
    chk("rst_led_c", 32'(led[2]), 32'd0);
    chk("rst_addr_a", 32'(addr[0]), 32'd0);
    chk("rst_busy_a", 32'(busy[0]), 32'd0);
    chk("rst_done_a", 32'(done[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // All three units start on the same edge.
    @(negedge clk);
    for (int u = 0; u < 3; u++) start[u] = 1'b1;
    @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) start[u] = 1'b0;
    chk("busy_a_e0", 32'(busy[0]), 32'd1);
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1;
      if (e == 4) chk("done_c_e4", 32'(done[2]), 32'd0);
      if (e == 5) chk("done_c_e5", 32'(done[2]), 32'd1);
      if (e == 5) chk("done_a_e5", 32'(done[0]), 32'd0);
      if (e == 6) chk("done_a_e6", 32'(done[0]), 32'd1);
    end
    wait_done(1, "done_b");

    for (int t = 0; t < 12; t++) begin
      show(tbl[t].u, tbl[t].s, tbl[t].exp, tbl[t].nm);
    end

    // Restart from DONE with a spurious start while busy.
    sel[0] = 2'b10;
    pulse(0);
    @(posedge clk);
    #1;
    chk("restart_addr0", 32'(addr[0]), 32'd0);
    chk("restart_busy", 32'(busy[0]), 32'd1);
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    for (int e = 3; e <= 6; e++) begin
      @(posedge clk);
      #1;
      if (e == 5) chk("restart_done_e5", 32'(done[0]), 32'd0);
      if (e == 6) chk("restart_done_e6", 32'(done[0]), 32'd1);
    end
    show(0, 2'b10, 8'h04, "restart_total");
    show(0, 2'b00, 8'h51, "restart_mix");

    // Asynchronous reset in the middle of a pass.
    sel[0] = 2'b11;
    pulse(0);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(busy[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_led", 32'(led[0]), 32'd0);
    chk("mid_rst_done", 32'(done[0]), 32'd0);
    chk("mid_rst_busy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sel[0] = 2'b00;
    pulse(0);
    wait_done(0, "post_rst_done");
    show(0, 2'b00, 8'h51, "post_rst_mix");
    show(0, 2'b10, 8'h04, "post_rst_total");

    // Register window edges: rd = 2, 3, 6, 7 with window 3..6.
    mem_a[0] = 32'h00211020;
    mem_a[1] = 32'h00211820;
    mem_a[2] = 32'h00213020;
    mem_a[3] = 32'h00213820;
    pulse(0);
    wait_done(0, "win_done");
    show(0, 2'b00, 8'h04, "win_mix");
    show(0, 2'b01, 8'h41, "win_regs");
    show(0, 2'b10, 8'h04, "win_total");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
